// File: rtl/amba_axi_pkg.sv
// rtl/amba_axi_pkg.sv - AXI widths, channel structs, splitter FSM states and burst address helpers
package amba_axi_pkg;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int USER_W = 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_BEAT, W_RESP, W_DONE} axi_wr_st_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} axi_rd_st_t;

    typedef struct packed {
        logic [ID_W-1:0]   awid;
        logic [ADDR_W-1:0] awaddr;
        logic [7:0]        awlen;
        logic [2:0]        awsize;
        logic [1:0]        awburst;
        logic              awlock;
        logic [3:0]        awcache;
        logic [2:0]        awprot;
        logic [3:0]        awqos;
        logic [3:0]        awregion;
        logic [USER_W-1:0] awuser;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              wlast;
        logic [USER_W-1:0] wuser;
        logic              wvalid;
        logic              bready;
        logic [ID_W-1:0]   arid;
        logic [ADDR_W-1:0] araddr;
        logic [7:0]        arlen;
        logic [2:0]        arsize;
        logic [1:0]        arburst;
        logic              arlock;
        logic [3:0]        arcache;
        logic [2:0]        arprot;
        logic [3:0]        arqos;
        logic [3:0]        arregion;
        logic [USER_W-1:0] aruser;
        logic              arvalid;
        logic              rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic              awready;
        logic              wready;
        logic [ID_W-1:0]   bid;
        logic [1:0]        bresp;
        logic [USER_W-1:0] buser;
        logic              bvalid;
        logic              arready;
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rlast;
        logic [USER_W-1:0] ruser;
        logic              rvalid;
    } s_axi_miso_t;

    // OKAY/SLVERR/DECERR encodings already rank by severity once EXOKAY folds to OKAY.
    function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] resp);
        logic [1:0] r;
        r = (resp == RESP_EXOKAY) ? RESP_OKAY : resp;
        return (r > acc) ? r : acc;
    endfunction

    function automatic logic [ADDR_W-1:0] burst_next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [2:0]        size,
        input logic [7:0]        len,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | ((addr + step) & mask);
            default:     return addr + step;
        endcase
    endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - next beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
    import amba_axi_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);
    assign next_addr = burst_next_addr(addr, size, len, burst);
endmodule

// File: rtl/axi_burst_split.sv
// rtl/axi_burst_split.sv - splits upstream AXI bursts into single-beat downstream transactions
module axi_burst_split
    import amba_axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  s_axi_mosi_t axi_mosi_i,
    output s_axi_miso_t axi_miso_o,
    output s_axi_mosi_t axi_mosi_o,
    input  s_axi_miso_t axi_miso_i
);
    axi_wr_st_t        w_state, w_state_nxt;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr, w_addr_nxt;
    logic [7:0]        w_len, w_beat;
    logic [2:0]        w_size, w_prot;
    logic [1:0]        w_burst, w_resp;
    logic              aw_done, w_done, aw_fire, w_fire;

    axi_rd_st_t        r_state, r_state_nxt;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr, r_addr_nxt;
    logic [7:0]        r_len, r_beat;
    logic [2:0]        r_size, r_prot;
    logic [1:0]        r_burst;
    logic              r_fire;

    logic unused_fields;
    assign unused_fields = ^{axi_mosi_i.awlock, axi_mosi_i.awcache, axi_mosi_i.awqos,
                             axi_mosi_i.awregion, axi_mosi_i.awuser, axi_mosi_i.wlast,
                             axi_mosi_i.wuser, axi_mosi_i.arlock, axi_mosi_i.arcache,
                             axi_mosi_i.arqos, axi_mosi_i.arregion, axi_mosi_i.aruser,
                             axi_miso_i.bid, axi_miso_i.buser, axi_miso_i.rid,
                             axi_miso_i.rlast, axi_miso_i.ruser};

    axi_burst_addr_gen u_wr_addr (.addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr(w_addr_nxt));
    axi_burst_addr_gen u_rd_addr (.addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr(r_addr_nxt));

    always_comb begin
        axi_miso_o  = '0;
        axi_mosi_o  = '0;
        w_state_nxt = w_state;
        r_state_nxt = r_state;
        aw_fire     = 1'b0;
        w_fire      = 1'b0;
        r_fire      = 1'b0;

        axi_mosi_o.awid    = w_id;
        axi_mosi_o.awaddr  = w_addr;
        axi_mosi_o.awsize  = w_size;
        axi_mosi_o.awburst = BURST_INCR;
        axi_mosi_o.awprot  = w_prot;
        axi_mosi_o.wdata   = axi_mosi_i.wdata;
        axi_mosi_o.wstrb   = axi_mosi_i.wstrb;
        axi_mosi_o.wlast   = 1'b1;
        axi_miso_o.bid     = w_id;
        axi_miso_o.bresp   = w_resp;
        axi_mosi_o.arid    = r_id;
        axi_mosi_o.araddr  = r_addr;
        axi_mosi_o.arsize  = r_size;
        axi_mosi_o.arburst = BURST_INCR;
        axi_mosi_o.arprot  = r_prot;
        axi_miso_o.rid     = r_id;
        axi_miso_o.rdata   = axi_miso_i.rdata;
        axi_miso_o.rresp   = axi_miso_i.rresp;

        case (w_state)
            W_IDLE: begin
                axi_miso_o.awready = 1'b1;
                if (axi_mosi_i.awvalid) w_state_nxt = W_BEAT;
            end
            W_BEAT: begin
                axi_mosi_o.awvalid = !aw_done;
                axi_mosi_o.wvalid  = axi_mosi_i.wvalid && !w_done;
                axi_miso_o.wready  = axi_miso_i.wready && !w_done;
                aw_fire = !aw_done && axi_miso_i.awready;
                w_fire  = axi_mosi_o.wvalid && axi_miso_i.wready;
                if ((aw_done || aw_fire) && (w_done || w_fire)) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                axi_mosi_o.bready = 1'b1;
                if (axi_miso_i.bvalid) w_state_nxt = (w_beat == w_len) ? W_DONE : W_BEAT;
            end
            default: begin
                axi_miso_o.bvalid = 1'b1;
                if (axi_mosi_i.bready) w_state_nxt = W_IDLE;
            end
        endcase

        case (r_state)
            R_IDLE: begin
                axi_miso_o.arready = 1'b1;
                if (axi_mosi_i.arvalid) r_state_nxt = R_ADDR;
            end
            R_ADDR: begin
                axi_mosi_o.arvalid = 1'b1;
                if (axi_miso_i.arready) r_state_nxt = R_DATA;
            end
            default: begin
                axi_miso_o.rvalid = axi_miso_i.rvalid;
                axi_miso_o.rlast  = (r_beat == r_len);
                axi_mosi_o.rready = axi_mosi_i.rready;
                r_fire = axi_miso_i.rvalid && axi_mosi_i.rready;
                if (r_fire) r_state_nxt = (r_beat == r_len) ? R_IDLE : R_ADDR;
            end
        endcase

        // Handshake signals stay quiet for the whole reset, not just after the first edge.
        if (!rst) begin
            axi_miso_o.awready = 1'b0;
            axi_miso_o.wready  = 1'b0;
            axi_miso_o.bvalid  = 1'b0;
            axi_miso_o.arready = 1'b0;
            axi_miso_o.rvalid  = 1'b0;
            axi_mosi_o.awvalid = 1'b0;
            axi_mosi_o.wvalid  = 1'b0;
            axi_mosi_o.bready  = 1'b0;
            axi_mosi_o.arvalid = 1'b0;
            axi_mosi_o.rready  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_prot  <= '0;
            w_beat  <= '0;
            w_resp  <= RESP_OKAY;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            case (w_state)
                W_IDLE: if (axi_mosi_i.awvalid) begin
                    w_id    <= axi_mosi_i.awid;
                    w_addr  <= axi_mosi_i.awaddr;
                    w_len   <= axi_mosi_i.awlen;
                    w_size  <= axi_mosi_i.awsize;
                    w_burst <= axi_mosi_i.awburst;
                    w_prot  <= axi_mosi_i.awprot;
                    w_beat  <= '0;
                    w_resp  <= RESP_OKAY;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                W_BEAT: if (w_state_nxt == W_RESP) begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end else begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
                W_RESP: if (axi_miso_i.bvalid) begin
                    w_resp <= merge_resp(w_resp, axi_miso_i.bresp);
                    if (w_beat != w_len) begin
                        w_beat <= w_beat + 8'd1;
                        w_addr <= w_addr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_prot  <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (r_state == R_IDLE && axi_mosi_i.arvalid) begin
                r_id    <= axi_mosi_i.arid;
                r_addr  <= axi_mosi_i.araddr;
                r_len   <= axi_mosi_i.arlen;
                r_size  <= axi_mosi_i.arsize;
                r_burst <= axi_mosi_i.arburst;
                r_prot  <= axi_mosi_i.arprot;
                r_beat  <= '0;
            end else if (r_fire && r_beat != r_len) begin
                r_beat <= r_beat + 8'd1;
                r_addr <= r_addr_nxt;
            end
        end
    end
endmodule
